scarv_ccx_arbiter: RTL and testbench
====================================

SCARV_CCX_ARBITER -- requirements
Module: scarv_ccx_arbiter

Interface
REQ-001 Parameter NREQ, default 2: number of requestor memory ports; legal range 2..8.
REQ-002 Parameter MODE, default 0: 0 = round-robin arbitration, 1 = fixed priority with lowest index highest.
REQ-003 Port g_clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port g_resetn, input, 1: asynchronous, active-low reset.
REQ-005 Ports m_req, m_wen, input, NREQ: per-requestor request and write enable.
REQ-006 Port m_strb, input, 4*NREQ: per-requestor write strobes; lane i occupies bits [4i+3:4i].
REQ-007 Ports m_wdata, m_addr, input, 32*NREQ: per-requestor write data and address; lane i occupies bits [32i+31:32i].
REQ-008 Port m_gnt, output, NREQ: per-requestor request accepted.
REQ-009 Port m_error, output, NREQ: per-requestor response error.
REQ-010 Port m_rdata, output, 32*NREQ: per-requestor read data.
REQ-011 Ports s_req, s_wen, output, 1; s_strb, output, 4; s_wdata, s_addr, output, 32: downstream request.
REQ-012 Port s_gnt, input, 1: downstream acceptance.
REQ-013 Port s_error, input, 1; port s_rdata, input, 32: downstream response, valid exactly one cycle after an accepted request.

Function
REQ-014 State consists of: lock (1b), lock_idx, ptr (round-robin start index) and rsp_pending (1b), rsp_idx; the index registers are clog2(NREQ) bits wide.
REQ-015 Unlocked winner selection, MODE 0: the first asserted m_req found searching upward from ptr, wrapping from NREQ-1 to 0.
REQ-016 Unlocked winner selection, MODE 1: the lowest asserted m_req index.
REQ-017 s_req SHALL be the OR of all m_req when unlocked, and m_req[lock_idx] when locked.
REQ-018 s_wen, s_strb, s_wdata and s_addr SHALL be the selected lane's fields (winner or lock_idx); they are all zero when s_req=0.
REQ-019 Acceptance occurs when s_req and s_gnt are both high in the same cycle.
REQ-020 On acceptance, m_gnt[selected] SHALL be 1 in that same cycle (combinational); all other m_gnt bits SHALL be 0.
REQ-021 On acceptance: lock<=0, rsp_pending<=1, rsp_idx<=selected.
REQ-022 On acceptance in MODE 0: ptr<=(selected+1) mod NREQ.
REQ-023 If s_req=1 and s_gnt=0 while unlocked: lock<=1 and lock_idx<=winner, so that the presented request stays stable until accepted.
REQ-024 While locked, no other requestor SHALL be selected, regardless of priority.
REQ-025 If the locked requestor drops m_req before acceptance (protocol violation): s_req=0 that cycle, no grant, and lock<=0 at the next edge.
REQ-026 Any cycle without acceptance: rsp_pending<=0.
REQ-027 m_rdata: every lane SHALL equal s_rdata (broadcast).
REQ-028 m_error[i] SHALL equal rsp_pending && rsp_idx==i && s_error.
REQ-029 Back-to-back acceptances on consecutive cycles SHALL be supported; the response for the cycle-N acceptance is routed at N+1 while the cycle-N+1 request is forwarded.
REQ-030 Simultaneous requests: exactly one grant per cycle.
REQ-031 MODE 0 fairness: with all requestors continuously requesting, each is granted once every NREQ acceptances.
REQ-032 Grant latency with s_gnt tied high: 0 cycles; response latency: 1 cycle.

Reset
REQ-033 While g_resetn=0: lock=0, lock_idx=0, ptr=0, rsp_pending=0, rsp_idx=0.
REQ-034 While g_resetn=0: s_req=0, all m_gnt=0, all m_error=0.
REQ-035 A reset asserted mid-transaction SHALL discard the pending lock and response with no grant or error emitted; the first request after release arbitrates from ptr=0.

Verification
REQ-036 NREQ=2, MODE=0, s_gnt=1, both m_req held high for 4 cycles -> m_gnt sequence 01,10,01,10 (bit0 first); ptr toggles 1,0,1,0.
REQ-037 MODE=1, NREQ=4, m_req=4'b1010 for 3 cycles -> m_gnt=4'b0010 every cycle; requestor 3 is never granted.
REQ-038 s_gnt=0 for 3 cycles with m_req[1] pending, then m_req[0] also raised, then s_gnt=1 -> s_addr stays at lane-1 address throughout; first grant goes to m_gnt[1].
REQ-039 Lane 2 read accepted, next cycle s_rdata=32'hDEADBEEF, s_error=1 -> m_error=only bit2, m_rdata lane2=32'hDEADBEEF; the following cycle m_error=0.
REQ-040 g_resetn pulsed low while locked on lane 1 with s_gnt=0 -> s_req=0 immediately; after release with m_req=all ones and MODE 0, lane 0 is granted first.

Source files
------------

// File: rtl/scarv_ccx_arbiter_if.sv
// scarv_ccx_arbiter_if: requestor-side and downstream memory bus bundle for the CCX arbiter
// m_*: NREQ requestor lanes (req/wen/strb/wdata/addr in, gnt/error/rdata out)
// s_*: single downstream port (req/wen/strb/wdata/addr out, gnt/error/rdata in)
// slave: arbiter view; master: environment view
interface scarv_ccx_arbiter_if #(parameter int NREQ = 2);
  logic [NREQ-1:0]    m_req, m_wen, m_gnt, m_error;
  logic [4*NREQ-1:0]  m_strb;
  logic [32*NREQ-1:0] m_wdata, m_addr, m_rdata;
  logic               s_req, s_wen, s_gnt, s_error;
  logic [3:0]         s_strb;
  logic [31:0]        s_wdata, s_addr, s_rdata;
  modport slave (
    input  m_req, m_wen, m_strb, m_wdata, m_addr, s_gnt, s_error, s_rdata,
    output m_gnt, m_error, m_rdata, s_req, s_wen, s_strb, s_wdata, s_addr
  );
  modport master (
    output m_req, m_wen, m_strb, m_wdata, m_addr, s_gnt, s_error, s_rdata,
    input  m_gnt, m_error, m_rdata, s_req, s_wen, s_strb, s_wdata, s_addr
  );
endinterface

// File: rtl/scarv_ccx_arbiter.sv
// scarv_ccx_arbiter: N-to-1 memory port arbiter (round-robin or fixed priority) with request locking
// g_clk: clock; g_resetn: async active-low reset
// b: bus bundle, requestor lanes m_* and downstream port s_*
module scarv_ccx_arbiter #(
  parameter int NREQ = 2,
  parameter int MODE = 0
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  scarv_ccx_arbiter_if.slave  b
);
  localparam int IW = $clog2(NREQ);
  localparam logic [IW:0] NR = (IW+1)'(NREQ);
  logic            r_lock, r_rsp_pending;
  logic [IW-1:0]   r_lock_idx, r_ptr, r_rsp_idx;
  logic [2*NREQ-2:0] w_req2;
  logic [NREQ-1:0] w_src;
  logic [IW-1:0]   w_off, w_win, w_sel, w_nxt;
  logic [IW:0]     w_sum;
  logic            w_acc;
  // rotate requests so that bit 0 is the lane at ptr; fixed priority searches unrotated
  assign w_req2 = {b.m_req[NREQ-2:0], b.m_req};
  assign w_src  = (MODE == 1) ? b.m_req : w_req2[r_ptr +: NREQ];
  always_comb begin
    w_off = '0;
    for (int k = NREQ-1; k >= 0; k--) w_off = w_src[k] ? IW'(k) : w_off;
  end
  assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win = (MODE == 1) ? w_off : (w_sum >= NR ? IW'(w_sum - NR) : w_sum[IW-1:0]);
  assign w_sel = r_lock ? r_lock_idx : w_win;
  assign w_nxt = (w_sel == IW'(NREQ-1)) ? '0 : w_sel + 1'b1;
  // combinational outputs are masked in reset since state alone would let |m_req through
  assign b.s_req   = g_resetn & (r_lock ? b.m_req[r_lock_idx] : |b.m_req);
  assign b.s_wen   = b.s_req & b.m_wen[w_sel];
  assign b.s_strb  = b.s_req ? b.m_strb[{w_sel, 2'b00} +: 4] : '0;
  assign b.s_wdata = b.s_req ? b.m_wdata[{w_sel, 5'b00000} +: 32] : '0;
  assign b.s_addr  = b.s_req ? b.m_addr[{w_sel, 5'b00000} +: 32] : '0;
  assign w_acc     = b.s_req & b.s_gnt;
  assign b.m_gnt   = w_acc ? (NREQ'(1) << w_sel) : '0;
  assign b.m_rdata = {NREQ{b.s_rdata}};
  always_comb begin
    b.m_error = '0;
    for (int i = 0; i < NREQ; i++) b.m_error[i] = r_rsp_pending & b.s_error & (r_rsp_idx == IW'(i));
  end
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_lock        <= 1'b0;
      r_lock_idx    <= '0;
      r_ptr         <= '0;
      r_rsp_pending <= 1'b0;
      r_rsp_idx     <= '0;
    end else begin
      r_rsp_pending <= w_acc;
      if (w_acc) begin
        r_lock    <= 1'b0;
        r_rsp_idx <= w_sel;
        if (MODE == 0) r_ptr <= w_nxt;
      end else if (b.s_req && !r_lock) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_win;
      end else if (r_lock && !b.s_req) begin
        r_lock <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_scarv_ccx_arbiter.sv
// tb_scarv_ccx_arbiter: directed-vector bench for scarv_ccx_arbiter in round-robin and fixed-priority modes
module tb_scarv_ccx_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  scarv_ccx_arbiter_if #(.NREQ(4)) ia ();
  scarv_ccx_arbiter_if #(.NREQ(4)) ib ();
  scarv_ccx_arbiter_if #(.NREQ(2)) ic ();
  scarv_ccx_arbiter #(.NREQ(4), .MODE(0)) u_a (.g_clk(clk), .g_resetn(rstn), .b(ia));
  scarv_ccx_arbiter #(.NREQ(4), .MODE(1)) u_b (.g_clk(clk), .g_resetn(rstn), .b(ib));
  scarv_ccx_arbiter #(.NREQ(2), .MODE(0)) u_c (.g_clk(clk), .g_resetn(rstn), .b(ic));
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  logic [1:0]  e_rr[4]  = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [31:0] e_ra[4]  = '{32'hA, 32'hB, 32'hA, 32'hB};
  initial begin
    {ia.m_req, ia.m_wen, ia.m_strb, ia.m_wdata, ia.s_gnt, ia.s_error, ia.s_rdata} = '0;
    {ib.m_req, ib.m_wen, ib.m_strb, ib.m_wdata, ib.m_addr, ib.s_gnt, ib.s_error, ib.s_rdata} = '0;
    {ic.m_req, ic.m_wen, ic.m_strb, ic.m_wdata, ic.s_gnt, ic.s_error, ic.s_rdata} = '0;
    ia.m_addr = {32'h1000_0030, 32'h1000_0020, 32'h1000_0010, 32'h1000_0000};
    ic.m_addr = {32'hB, 32'hA};
    // outputs held quiet in reset even with requests, grant and error present
    ia.m_req = 4'b1111; ia.s_gnt = 1'b1; ia.s_error = 1'b1;
    #1;
    chk("rst_sreq", ia.s_req, 1'b0);
    chk("rst_gnt", ia.m_gnt, 4'b0000);
    chk("rst_err", ia.m_error, 4'b0000);
    chk("rst_addr", ia.s_addr, 32'h0);
    ia.m_req = '0; ia.s_gnt = 1'b0; ia.s_error = 1'b0;
    cyc();
    rstn = 1'b1;
    // round-robin, NREQ=2, both requesting
    ic.m_req = 2'b11; ic.s_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_gnt", ic.m_gnt, e_rr[i]);
      chk("rr_addr", ic.s_addr, e_ra[i]);
      cyc();
    end
    ic.m_req = '0;
    // fixed priority, lane 3 starved
    ib.m_req = 4'b1010; ib.s_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fp_gnt", ib.m_gnt, 4'b0010);
      cyc();
    end
    ib.m_req = '0;
    // lock on lane 1 while downstream stalls
    ia.m_req = 4'b0010; ia.s_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lk_sreq", ia.s_req, 1'b1);
      chk("lk_addr", ia.s_addr, 32'h1000_0010);
      chk("lk_gnt", ia.m_gnt, 4'b0000);
      cyc();
    end
    ia.m_req = 4'b0011;
    #1;
    chk("lk_hold", ia.s_addr, 32'h1000_0010);
    cyc();
    ia.s_gnt = 1'b1;
    #1;
    chk("lk_gnt1", ia.m_gnt, 4'b0010);
    chk("lk_addr1", ia.s_addr, 32'h1000_0010);
    cyc();
    // back-to-back: ptr=2, search 2,3,0 finds lane 0
    #1;
    chk("b2b_gnt0", ia.m_gnt, 4'b0001);
    chk("b2b_addr0", ia.s_addr, 32'h1000_0000);
    cyc();
    // lane 2 write, then response with error
    ia.m_req = 4'b0100; ia.m_wen = 4'b0100;
    ia.m_strb = 16'h0A00; ia.m_wdata = {32'h0, 32'hCAFE0002, 64'h0};
    #1;
    chk("l2_gnt", ia.m_gnt, 4'b0100);
    chk("l2_wen", ia.s_wen, 1'b1);
    chk("l2_strb", ia.s_strb, 4'hA);
    chk("l2_wdata", ia.s_wdata, 32'hCAFE0002);
    cyc();
    ia.m_req = '0; ia.s_rdata = 32'hDEADBEEF; ia.s_error = 1'b1;
    #1;
    chk("rsp_err", ia.m_error, 4'b0100);
    chk("rsp_rdata2", ia.m_rdata[95:64], 32'hDEADBEEF);
    chk("rsp_rdata0", ia.m_rdata[31:0], 32'hDEADBEEF);
    chk("idle_sreq", ia.s_req, 1'b0);
    chk("idle_strb", ia.s_strb, 4'h0);
    chk("idle_wdata", ia.s_wdata, 32'h0);
    cyc();
    chk("rsp_err_clr", ia.m_error, 4'b0000);
    ia.s_error = 1'b0; ia.m_wen = '0; ia.m_strb = '0; ia.m_wdata = '0;
    // ptr=3: lock on lane 1, then reset mid-transaction
    ia.m_req = 4'b0010; ia.s_gnt = 1'b0;
    cyc();
    chk("pre_rst_sreq", ia.s_req, 1'b1);
    rstn = 1'b0;
    ia.s_gnt = 1'b1;
    #1;
    chk("mid_rst_sreq", ia.s_req, 1'b0);
    chk("mid_rst_gnt", ia.m_gnt, 4'b0000);
    cyc();
    rstn = 1'b1;
    ia.m_req = 4'b1111;
    #1;
    chk("post_rst_gnt", ia.m_gnt, 4'b0001);
    cyc();
    // ptr=1: lock on lane 1, then lane 1 drops its request
    ia.m_req = 4'b0010; ia.s_gnt = 1'b0;
    cyc();
    ia.m_req = 4'b0100; ia.s_gnt = 1'b1;
    #1;
    chk("drop_sreq", ia.s_req, 1'b0);
    chk("drop_gnt", ia.m_gnt, 4'b0000);
    cyc();
    chk("drop_next", ia.m_gnt, 4'b0100);
    cyc();
    ia.m_req = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
